// File: rtl/m68k_bus_pkg.sv
// Shared types, default address map and helpers for the 68000 bus decoder.
package m68k_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    EXTWAIT,
    ACK,
    ERR
  } bus_state_e;

  // Widest region map that onehot_priority can resolve.
  localparam int MAX_REGIONS = 32;

  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK  = 32'hFFFF_8000;
  localparam logic [31:0] RAM_BASE  = 32'h0800_0000;
  localparam logic [31:0] RAM_MASK  = 32'hFFFC_0000;
  localparam logic [31:0] IO_BASE   = 32'h0040_0000;
  localparam logic [31:0] IO_MASK   = 32'hFFFF_0000;
  localparam logic [31:0] DRAM_BASE = 32'hF000_0000;
  localparam logic [31:0] DRAM_MASK = 32'hFC00_0000;

  localparam logic [127:0] DEFAULT_REGION_BASE = {DRAM_BASE, IO_BASE, RAM_BASE, ROM_BASE};
  localparam logic [127:0] DEFAULT_REGION_MASK = {DRAM_MASK, IO_MASK, RAM_MASK, ROM_MASK};
  localparam logic [15:0]  DEFAULT_REGION_WAIT = {4'd0, 4'd2, 4'd1, 4'd0};
  localparam logic [3:0]   DEFAULT_EXT_ACK     = 4'b1000;

  // Keep only the lowest set bit: lowest region index wins.
  function automatic logic [MAX_REGIONS-1:0] onehot_priority(input logic [MAX_REGIONS-1:0] hit);
    return hit & (~hit + MAX_REGIONS'(1));
  endfunction

endpackage

// File: rtl/m68k_wait_state_decoder_region_match.sv
// Combinational base/mask compare of the address against every region,
// reduced to a priority one-hot hit plus the winning region index.
module region_match
  import m68k_bus_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int ADDR_W      = 32,
  parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = DEFAULT_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = DEFAULT_REGION_MASK
) (
  input  logic [ADDR_W-1:0]      address,
  output logic [NUM_REGIONS-1:0] onehot,
  output logic [IDX_W-1:0]       index
);

  logic [NUM_REGIONS-1:0] hit;
  logic [MAX_REGIONS-1:0] hit_wide;
  logic [MAX_REGIONS-1:0] sel_wide;
  logic                   unused_sel;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      hit[i] = ((address & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]);
    end
  end

  always_comb begin
    hit_wide = '0;
    hit_wide[NUM_REGIONS-1:0] = hit;
  end

  assign sel_wide   = onehot_priority(hit_wide);
  assign onehot     = sel_wide[NUM_REGIONS-1:0];
  assign unused_sel = &{1'b0, sel_wide};

  always_comb begin
    index = '0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (hit[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/m68k_wait_state_decoder.sv
// 68000 chip-select decoder with per-region wait states, external acknowledge
// for slow regions, and bus error on unmapped access or acknowledge timeout.
module m68k_wait_state_decoder
  import m68k_bus_pkg::*;
#(
  parameter int NUM_REGIONS    = 4,
  parameter int ADDR_W         = 32,
  parameter int WAIT_W         = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE    = DEFAULT_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK    = DEFAULT_REGION_MASK,
  parameter logic [NUM_REGIONS*WAIT_W-1:0] REGION_WAIT    = DEFAULT_REGION_WAIT,
  parameter logic [NUM_REGIONS-1:0]        REGION_EXT_ACK = DEFAULT_EXT_ACK
) (
  input  logic                   Clk,
  input  logic                   Reset_L,
  input  logic [ADDR_W-1:0]      Address,
  input  logic                   AS_L,
  input  logic                   ExtDtack_L,
  output logic [NUM_REGIONS-1:0] Select_H,
  output logic                   DTACK_L,
  output logic                   BERR_L,
  output logic                   Busy_H
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  bus_state_e             state;
  logic [NUM_REGIONS-1:0] hit_onehot;
  logic [IDX_W-1:0]       hit_index;
  logic [WAIT_W-1:0]      wait_cnt;
  logic [TMO_W-1:0]       tmo_cnt;

  region_match #(
    .NUM_REGIONS(NUM_REGIONS),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .REGION_BASE(REGION_BASE),
    .REGION_MASK(REGION_MASK)
  ) u_region_match (
    .address(Address),
    .onehot (hit_onehot),
    .index  (hit_index)
  );

  // AS_L going high in WAIT/EXTWAIT aborts the cycle before any other check.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state    <= IDLE;
      Select_H <= '0;
      DTACK_L  <= 1'b1;
      BERR_L   <= 1'b1;
      Busy_H   <= 1'b0;
      wait_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!AS_L) begin
            Busy_H <= 1'b1;
            if (|hit_onehot) begin
              Select_H <= hit_onehot;
              if (REGION_EXT_ACK[hit_index]) begin
                state   <= EXTWAIT;
                tmo_cnt <= '0;
              end else begin
                state    <= WAIT;
                wait_cnt <= REGION_WAIT[int'(hit_index)*WAIT_W +: WAIT_W];
              end
            end else begin
              state  <= ERR;
              BERR_L <= 1'b0;
            end
          end
        end
        WAIT: begin
          if (AS_L) begin
            state    <= IDLE;
            Select_H <= '0;
            Busy_H   <= 1'b0;
          end else if (wait_cnt == '0) begin
            state   <= ACK;
            DTACK_L <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        EXTWAIT: begin
          if (AS_L) begin
            state    <= IDLE;
            Select_H <= '0;
            Busy_H   <= 1'b0;
          end else if (!ExtDtack_L) begin
            state   <= ACK;
            DTACK_L <= 1'b0;
          end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state    <= ERR;
            BERR_L   <= 1'b0;
            Select_H <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        ACK: begin
          if (AS_L) begin
            state    <= IDLE;
            DTACK_L  <= 1'b1;
            Select_H <= '0;
            Busy_H   <= 1'b0;
          end
        end
        ERR: begin
          if (AS_L) begin
            state  <= IDLE;
            BERR_L <= 1'b1;
            Busy_H <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          Select_H <= '0;
          DTACK_L  <= 1'b1;
          BERR_L   <= 1'b1;
          Busy_H   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_m68k_wait_state_decoder.sv
// Self-checking bench: per-edge expectations come from a transaction-level
// model of the address map, wait counts and acknowledge/timeout rules.
module tb_m68k_wait_state_decoder;

  localparam int NR  = 4;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset_l;
  logic [31:0] address;
  logic        as_l;
  logic        ext_l;
  logic [3:0]  sel;
  logic        dtack_l, berr_l, busy;
  logic [3:0]  sel_o;
  logic        dtack_o, berr_o, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] base0[NR], mask0[NR], base1[NR], mask1[NR];
  int          mwait[NR];
  bit          mext[NR];

  always #5 clk = ~clk;

  m68k_wait_state_decoder dut (
    .Clk(clk), .Reset_L(reset_l), .Address(address), .AS_L(as_l), .ExtDtack_L(ext_l),
    .Select_H(sel), .DTACK_L(dtack_l), .BERR_L(berr_l), .Busy_H(busy)
  );

  m68k_wait_state_decoder #(
    .REGION_BASE({32'hF000_0000, 32'h0040_0000, 32'h0000_0000, 32'h0000_0000}),
    .REGION_MASK({32'hFC00_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000})
  ) dut_ovl (
    .Clk(clk), .Reset_L(reset_l), .Address(address), .AS_L(as_l), .ExtDtack_L(ext_l),
    .Select_H(sel_o), .DTACK_L(dtack_o), .BERR_L(berr_o), .Busy_H(busy_o)
  );

  function automatic int model_region(input int m, input logic [31:0] a);
    for (int i = 0; i < NR; i++) begin
      if (m == 0 && (a & mask0[i]) == base0[i]) return i;
      if (m == 1 && (a & mask1[i]) == base1[i]) return i;
    end
    return -1;
  endfunction

  // One complete bus cycle: j = edge (after k) where ExtDtack_L is sampled low
  // (0 = never), h = extra edges AS_L stays low after the response, ab = edge
  // at which AS_L is sampled high early (0 = no abort).
  task automatic drive_cycle(input logic [31:0] a, input int j, input int h,
                             input int ab, input string name);
    int r, t, rr, last;
    bit ack, ext, aborted;
    logic [3:0] oh;
    logic [6:0] exp_q[$];
    logic [6:0] obs, e;
    r   = model_region(0, a);
    oh  = (r >= 0) ? 4'(1 << r) : 4'b0000;
    ext = (r >= 0) && mext[r];
    if (r < 0) begin
      t = 0; ack = 0;
    end else if (ext) begin
      t = (j != 0) ? j : TMO; ack = (j != 0);
    end else begin
      t = 1 + mwait[r]; ack = 1;
    end
    aborted = (ab != 0) && (ab <= t);
    rr   = t + 1 + h;
    last = aborted ? ab : rr;
    for (int n = 0; n <= last; n++) begin
      if ((aborted && n >= ab) || n >= rr) e = {1'b0, 1'b1, 1'b1, 4'b0000};
      else if (n < t)                      e = {1'b1, 1'b1, 1'b1, oh};
      else if (ack)                        e = {1'b1, 1'b1, 1'b0, oh};
      else                                 e = {1'b1, 1'b0, 1'b1, 4'b0000};
      exp_q.push_back(e);
    end
    address = a;
    as_l    = 1'b0;
    ext_l   = ext ? 1'b1 : 1'($urandom_range(0, 1));
    for (int n = 0; n <= last; n++) begin
      @(posedge clk); #1;
      obs = {busy, berr_l, dtack_l, sel};
      e   = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL %s edge k+%0d: busy,berr,dtack,sel got %b required %b", name, n, obs, e);
      end
      n_cmp++;
      if (!dtack_l && !berr_l) begin
        n_bad++;
        $display("FAIL %s exclusion edge k+%0d: dtack=%b berr=%b required not both 0", name, n, dtack_l, berr_l);
      end
      as_l = ((aborted && n + 1 == ab) || (!aborted && n + 1 == rr)) ? 1'b1 : 1'b0;
      if (ext) ext_l = !(j != 0 && n + 1 == j);
      else     ext_l = 1'($urandom_range(0, 1));
    end
    as_l  = 1'b1;
    ext_l = 1'b1;
  endtask

  task automatic test_reset();
    reset_l = 1'b0;
    address = 32'h0800_0000;
    as_l    = 1'b0;
    ext_l   = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, berr_l, dtack_l, sel} !== 7'b0110000) begin
        n_bad++;
        $display("FAIL reset_hold: got %b required 0110000", {busy, berr_l, dtack_l, sel});
      end
    end
    reset_l = 1'b1;
    drive_cycle(32'h0800_0000, 0, 1, 0, "reset_release");
  endtask

  task automatic test_reset_abort();
    address = 32'h0040_0000;
    as_l    = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_l = 1'b0;
    #1;
    n_cmp++;
    if ({busy, berr_l, dtack_l, sel} !== 7'b0110000) begin
      n_bad++;
      $display("FAIL reset_async: got %b required 0110000", {busy, berr_l, dtack_l, sel});
    end
    @(posedge clk); #1;
    as_l    = 1'b1;
    reset_l = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, berr_l, dtack_l, sel} !== 7'b0110000) begin
      n_bad++;
      $display("FAIL reset_after: got %b required 0110000", {busy, berr_l, dtack_l, sel});
    end
  endtask

  task automatic test_wait_states();
    drive_cycle(32'h0040_1234, 0, 0, 0, "wait_io");
    drive_cycle(32'h0000_0100, 0, 2, 0, "wait_rom");
    drive_cycle(32'h0803_FFFC, 0, 3, 0, "wait_ram");
  endtask

  task automatic test_unmapped();
    drive_cycle(32'h1000_0000, 0, 2, 0, "unmapped");
    drive_cycle(32'h0000_8000, 0, 0, 0, "unmapped_rom_edge");
  endtask

  task automatic test_ext_ack();
    drive_cycle(32'hF000_0100, 5, 1, 0, "ext_ack");
    drive_cycle(32'hF3FF_FFFF, 1, 0, 0, "ext_ack_fast");
  endtask

  task automatic test_ext_timeout();
    drive_cycle(32'hF000_0100, 0, 1, 0, "ext_timeout");
    drive_cycle(32'hF000_0200, TMO, 0, 0, "ext_ack_on_timeout");
  endtask

  task automatic test_abort();
    drive_cycle(32'h0040_0000, 0, 0, 1, "abort_wait");
    drive_cycle(32'h0040_0000, 0, 0, 3, "abort_on_expiry");
    drive_cycle(32'hF000_0000, 0, 0, 7, "abort_ext");
    drive_cycle(32'hF000_0000, 4, 0, 4, "abort_vs_ext");
  endtask

  task automatic test_overlap();
    int r;
    logic [3:0] oh;
    r  = model_region(1, 32'h0000_0010);
    oh = (r >= 0) ? 4'(1 << r) : 4'b0000;
    address = 32'h0000_0010;
    as_l    = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (sel_o !== oh || dtack_o !== 1'b1) begin
      n_bad++;
      $display("FAIL overlap_select: sel=%b dtack=%b required sel=%b dtack=1", sel_o, dtack_o, oh);
    end
    repeat (mwait[r]) @(posedge clk);
    @(posedge clk); #1;
    n_cmp++;
    if (sel_o !== oh || dtack_o !== 1'b0 || berr_o !== 1'b1) begin
      n_bad++;
      $display("FAIL overlap_ack: sel=%b dtack=%b berr=%b required sel=%b dtack=0 berr=1", sel_o, dtack_o, berr_o, oh);
    end
    as_l = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy_o, berr_o, dtack_o, sel_o} !== 7'b0110000) begin
      n_bad++;
      $display("FAIL overlap_release: got %b required 0110000", {busy_o, berr_o, dtack_o, sel_o});
    end
  endtask

  task automatic test_random(input int count, input string name);
    logic [31:0] a;
    int r, j, h, ab;
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = $urandom;
      end else begin
        r = $urandom_range(0, NR - 1);
        a = base0[r] | ($urandom & ~mask0[r]);
      end
      j  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 30);
      h  = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      drive_cycle(a, j, h, ab, name);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    base0 = '{32'h0000_0000, 32'h0800_0000, 32'h0040_0000, 32'hF000_0000};
    mask0 = '{32'hFFFF_8000, 32'hFFFC_0000, 32'hFFFF_0000, 32'hFC00_0000};
    base1 = '{32'h0000_0000, 32'h0000_0000, 32'h0040_0000, 32'hF000_0000};
    mask1 = '{32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFC00_0000};
    mwait = '{0, 1, 2, 0};
    mext  = '{0, 0, 0, 1};
    reset_l = 1'b0;
    address = '0;
    as_l    = 1'b1;
    ext_l   = 1'b1;

    test_reset();
    test_wait_states();
    test_unmapped();
    test_ext_ack();
    test_ext_timeout();
    test_abort();
    test_reset_abort();
    test_overlap();
    test_random(8, "back_to_back");
    test_random(60, "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/m68k_wait_state_decoder.md
Name: m68k_wait_state_decoder

Overview:
Parametrised successor to the combinational chip-select decoder. It holds an N-region base/mask address map and registers one-hot chip selects on each 68000 bus cycle. It generates DTACK_L after a per-region wait-state count, or after an external acknowledge for slow or off-board regions. BERR_L is raised on an unmapped address or an external-ack timeout. It sits between the CPU bus (AS_L, Address) and the memory/IO select lines.

Parameters:
NUM_REGIONS, 4, number of decoded regions.
ADDR_W, 32, address width.
WAIT_W, 4, width of per-region wait count.
TIMEOUT_CYCLES, 255, max cycles to wait for ExtDtack_L before BERR.
REGION_BASE, {F000_0000, 0040_0000, 0800_0000, 0000_0000}, packed NUM_REGIONS*ADDR_W bases. Region 0 is in the LSBs.
REGION_MASK, {FC00_0000, FFFF_0000, FFFC_0000, FFFF_8000}, packed compare masks.
REGION_WAIT, {0, 2, 1, 0}, packed NUM_REGIONS*WAIT_W internal wait counts.
REGION_EXT_ACK, 4'b1000, bit i=1 means region i waits for ExtDtack_L and ignores REGION_WAIT.

Ports:
Clk  in  1  system clock, rising edge.
Reset_L  in  1  asynchronous active-low reset.
Address  in  ADDR_W  CPU address, valid while AS_L low.
AS_L  in  1  CPU address strobe, active low.
ExtDtack_L  in  1  external acknowledge from slow/off-board target, active low.
Select_H  out  NUM_REGIONS  registered one-hot chip selects.
DTACK_L  out  1  data transfer acknowledge to CPU, active low.
BERR_L  out  1  bus error to CPU, active low.
Busy_H  out  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset (async, Reset_L=0): state IDLE, Select_H=0, DTACK_L=1, BERR_L=1, Busy_H=0, counters=0. Reset asserted mid-cycle aborts immediately.
- Match: hit[i] = ((Address & MASK[i]) == BASE[i]).
- Priority: lowest index wins; Select_H is always one-hot or zero.
- States: IDLE, WAIT, EXTWAIT, ACK, ERR.
- IDLE: at the edge where AS_L is sampled 0 (edge k):
  - no hit -> ERR; BERR_L=0 after edge k; Select_H stays 0.
  - hit on region i -> Select_H[i]=1 after edge k.
    - If EXT_ACK[i]: go to EXTWAIT, timeout counter=0.
    - Otherwise: go to WAIT, wait counter=REGION_WAIT[i].
- WAIT: each edge, if counter==0 -> ACK, else decrement. DTACK_L falls after edge k+1+REGION_WAIT[i].
- EXTWAIT: each edge:
  - ExtDtack_L sampled 0 -> ACK.
  - else if counter==TIMEOUT_CYCLES-1 -> ERR and Select_H cleared.
  - else increment counter.
  - ExtDtack_L low on the timeout edge: ack wins.
- ACK: DTACK_L=0 and Select_H held until AS_L is sampled 1. Then IDLE, with DTACK_L=1 and Select_H=0 after that edge.
- ERR: BERR_L=0 until AS_L is sampled 1, then IDLE with BERR_L=1.
- Abort: AS_L sampled 1 in WAIT or EXTWAIT -> IDLE with all outputs inactive. This has priority over counter expiry and ExtDtack_L.
- Back-to-back cycles: AS_L must be sampled 1 for at least one edge. A new cycle starts only from IDLE.
- Mutual exclusion: DTACK_L and BERR_L are never low together.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1). It must not wrap.

Decomposition:
- Package m68k_bus_pkg holds:
  - state enum (IDLE, WAIT, EXTWAIT, ACK, ERR).
  - default map constants (ROM/RAM/IO/DRAM base and mask).
  - function onehot_priority(hit).
- One sub-module, region_match: combinational, parameterised on NUM_REGIONS/ADDR_W. It outputs the one-hot priority hit and the region index.
- The FSM and counters live in the top module.

Test Plan:
1. Reset held, Address=0800_0000, AS_L=0 -> all outputs inactive. Release reset -> Select_H=0010, DTACK_L low 2 edges after AS_L is sampled low (wait=1).
2. Address=0040_1234, AS_L low at edge k -> Select_H=0100 after k, DTACK_L low after k+3. AS_L high -> Select_H=0000 and DTACK_L=1 on the next edge.
3. Address=1000_0000 (unmapped) -> BERR_L=0 after edge k, Select_H=0000, DTACK_L=1 throughout. BERR_L clears after AS_L returns high.
4. Address=F000_0100, ExtDtack_L low at cycle 5 -> Select_H=1000, DTACK_L low on the following edge. ExtDtack_L never low -> BERR_L low after 255 cycles, Select_H=0000.
5. Address=0040_0000, AS_L released after 1 cycle in WAIT -> FSM back to IDLE, DTACK_L never asserts, Busy_H=0.
6. Region overlap: REGION_BASE[1]=REGION_BASE[0]=0, masks FFFF_0000 -> Address=0000_0010 selects region 0 only (Select_H=0001).
